// File: rtl/gtp_gmii_rx_align_pkg.sv
// Shared constants, FSM encoding and comma detection for the GTP->GMII RX gearbox.
package gtp_gmii_rx_align_pkg;

    localparam logic [9:0] K28P = 10'h17C;
    localparam logic [9:0] K28N = 10'h283;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOCK  = 2'd2
    } lock_state_e;

    function automatic logic is_comma(input logic [9:0] sym);
        return (sym == K28P) || (sym == K28N);
    endfunction

endpackage

// File: rtl/gtp_gmii_rx_align_comma_lock.sv
// Comma-half lock FSM: picks which half of the GTP word carries K28.5 and
// reports that choice (cand_o) once it has been stable for LOCK_CNT commas.
module gtp_gmii_rx_align_comma_lock
    import gtp_gmii_rx_align_pkg::*;
#(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic stb_i,
    input  logic c_lo_i,
    input  logic c_hi_i,
    output logic cand_o,
    output logic locked_o,
    output logic realign_o
);

    localparam logic [3:0] LOCK_N   = LOCK_CNT[3:0];
    localparam logic [3:0] UNLOCK_N = UNLOCK_CNT[3:0];

    lock_state_e state_q;
    logic        cand_q;
    logic        locked_q;
    logic        realign_q;
    logic [3:0]  cnt_q;
    logic [3:0]  bad_q;
    logic        single;

    // A word with commas in both halves is illegal and never selects a half.
    assign single = c_lo_i ^ c_hi_i;

    // Lock state machine, advanced only on new GTP words.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_HUNT;
            cand_q    <= 1'b0;
            locked_q  <= 1'b0;
            realign_q <= 1'b0;
            cnt_q     <= 4'd0;
            bad_q     <= 4'd0;
        end else begin
            realign_q <= 1'b0;
            if (stb_i) begin
                case (state_q)
                    ST_HUNT: begin
                        if (single) begin
                            cand_q    <= c_hi_i;
                            realign_q <= (c_hi_i != cand_q);
                            cnt_q     <= 4'd1;
                            if (LOCK_N == 4'd1) begin
                                state_q  <= ST_LOCK;
                                locked_q <= 1'b1;
                            end else begin
                                state_q <= ST_CHECK;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (single) begin
                            if (c_hi_i == cand_q) begin
                                cnt_q <= cnt_q + 4'd1;
                                if (cnt_q + 4'd1 == LOCK_N) begin
                                    state_q  <= ST_LOCK;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                cand_q    <= c_hi_i;
                                realign_q <= 1'b1;
                                cnt_q     <= 4'd1;
                            end
                        end
                    end
                    ST_LOCK: begin
                        if (single && (c_hi_i == cand_q)) begin
                            bad_q <= 4'd0;
                        end else if (c_lo_i || c_hi_i) begin
                            if (bad_q + 4'd1 == UNLOCK_N) begin
                                state_q  <= ST_HUNT;
                                locked_q <= 1'b0;
                                bad_q    <= 4'd0;
                                cnt_q    <= 4'd0;
                            end else begin
                                bad_q <= bad_q + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_q  <= ST_HUNT;
                        locked_q <= 1'b0;
                        cnt_q    <= 4'd0;
                        bad_q    <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign cand_o    = cand_q;
    assign locked_o  = locked_q;
    assign realign_o = realign_q;

endmodule

// File: rtl/gtp_gmii_rx_align.sv
// RX half of the GTP<->GMII 2:1 gearbox: re-pairs 20-bit GTP words on the
// comma boundary and emits one aligned 10-bit symbol per gmii_rx_clk.
module gtp_gmii_rx_align
    import gtp_gmii_rx_align_pkg::*;
#(
    parameter int DW         = 10,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 4
) (
    input  logic            gmii_rx_clk,
    input  logic            rst_n,
    input  logic [2*DW-1:0] gtp_rxd,
    input  logic            gtp_word_stb,
    output logic [DW-1:0]   gmii_rxd,
    output logic            locked,
    output logic            slot,
    output logic            realign,
    output logic            stb_err
);

    logic [DW-1:0]   rxd_q, rxd_d;
    logic [2*DW-1:0] hold_q, hold_d;
    logic            ph_q, ph_d;
    logic            armed_q, armed_d;
    logic            stb_err_q, stb_err_d;
    logic            c_lo, c_hi;
    logic            cand;

    assign c_lo = is_comma(gtp_rxd[DW-1:0]);
    assign c_hi = is_comma(gtp_rxd[2*DW-1:DW]);

    gtp_gmii_rx_align_comma_lock #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lock (
        .clk_i     (gmii_rx_clk),
        .rst_n_i   (rst_n),
        .stb_i     (gtp_word_stb),
        .c_lo_i    (c_lo),
        .c_hi_i    (c_hi),
        .cand_o    (cand),
        .locked_o  (locked),
        .realign_o (realign)
    );

    // Symbol mux; cand is still the old slot on the edge that decides a new one.
    always_comb begin
        rxd_d     = rxd_q;
        hold_d    = hold_q;
        ph_d      = 1'b0;
        armed_d   = armed_q;
        stb_err_d = 1'b0;
        if (gtp_word_stb) begin
            hold_d    = gtp_rxd;
            ph_d      = 1'b1;
            armed_d   = 1'b1;
            stb_err_d = ph_q;
            if (cand) begin
                rxd_d = hold_q[2*DW-1:DW];
            end else begin
                rxd_d = gtp_rxd[DW-1:0];
            end
        end else if (ph_q) begin
            if (cand) begin
                rxd_d = hold_q[DW-1:0];
            end else begin
                rxd_d = hold_q[2*DW-1:DW];
            end
        end else begin
            stb_err_d = armed_q;
        end
    end

    // Datapath registers; a reset discards any pending second symbol.
    always_ff @(posedge gmii_rx_clk) begin
        if (!rst_n) begin
            rxd_q     <= '0;
            hold_q    <= '0;
            ph_q      <= 1'b0;
            armed_q   <= 1'b0;
            stb_err_q <= 1'b0;
        end else begin
            rxd_q     <= rxd_d;
            hold_q    <= hold_d;
            ph_q      <= ph_d;
            armed_q   <= armed_d;
            stb_err_q <= stb_err_d;
        end
    end

    assign gmii_rxd = rxd_q;
    assign slot     = cand;
    assign stb_err  = stb_err_q;

endmodule

// File: tb/tb_gtp_gmii_rx_align.sv
// Randomized self-checking bench for gtp_gmii_rx_align against a behavioural model.
module tb_gtp_gmii_rx_align;

    localparam int LOCK_CNT   = 3;
    localparam int UNLOCK_CNT = 4;
    localparam logic [9:0] KP = 10'h17C;
    localparam logic [9:0] KN = 10'h283;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] gtp_rxd = 20'd0;
    logic        gtp_word_stb = 1'b0;
    logic [9:0]  gmii_rxd;
    logic        locked, slot, realign, stb_err;

    int checks = 0;
    int errors = 0;

    // model state
    logic [9:0]  m_rxd;
    logic [19:0] m_word;
    logic        m_prev_stb, m_seen;
    logic        m_slot, m_locked, m_realign, m_err;
    int          m_run, m_bad;

    gtp_gmii_rx_align #(
        .DW         (10),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) dut (
        .gmii_rx_clk  (clk),
        .rst_n        (rst_n),
        .gtp_rxd      (gtp_rxd),
        .gtp_word_stb (gtp_word_stb),
        .gmii_rxd     (gmii_rxd),
        .locked       (locked),
        .slot         (slot),
        .realign      (realign),
        .stb_err      (stb_err)
    );

    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_k(input logic [9:0] s);
        return (s == KP) || (s == KN);
    endfunction

    function automatic logic [9:0] rnd_data();
        logic [9:0] d;
        d = 10'($urandom);
        if (is_k(d)) d = d ^ 10'h001;
        return d;
    endfunction

    function automatic logic [9:0] rnd_k();
        return ($urandom % 2 == 0) ? KP : KN;
    endfunction

    task automatic model_reset();
        m_rxd = 10'd0; m_word = 20'd0; m_prev_stb = 1'b0; m_seen = 1'b0;
        m_slot = 1'b0; m_locked = 1'b0; m_realign = 1'b0; m_err = 1'b0;
        m_run = 0; m_bad = 0;
    endtask

    // Lock rule: LOCK_CNT commas in one half lock it; UNLOCK_CNT wrong ones drop it.
    task automatic model_lock(input logic [19:0] w);
        logic lo, hi, one;
        lo = is_k(w[9:0]);
        hi = is_k(w[19:10]);
        one = lo ^ hi;
        if (!m_locked) begin
            if (one) begin
                if (m_run == 0 || hi != m_slot) begin
                    m_realign = (hi != m_slot);
                    m_slot = hi;
                    m_run = 1;
                end else begin
                    m_run++;
                end
                if (m_run >= LOCK_CNT) m_locked = 1'b1;
            end
        end else if (one && hi == m_slot) begin
            m_bad = 0;
        end else if (lo || hi) begin
            m_bad++;
            if (m_bad >= UNLOCK_CNT) begin
                m_locked = 1'b0;
                m_bad = 0;
                m_run = 0;
            end
        end
    endtask

    task automatic model_edge(input logic stb, input logic [19:0] w, input logic rn);
        logic old_slot;
        if (!rn) begin
            model_reset();
        end else begin
            old_slot  = m_slot;
            m_realign = 1'b0;
            m_err     = 1'b0;
            if (stb) begin
                m_err  = m_prev_stb;
                m_rxd  = old_slot ? m_word[19:10] : w[9:0];
                m_word = w;
                model_lock(w);
                m_seen = 1'b1;
            end else if (m_prev_stb) begin
                m_rxd = m_slot ? m_word[9:0] : m_word[19:10];
            end else begin
                m_err = m_seen;
            end
            m_prev_stb = stb;
        end
    endtask

    task automatic step(input logic stb, input logic [19:0] w, input logic rn);
        @(negedge clk);
        gtp_word_stb = stb;
        gtp_rxd      = w;
        rst_n        = rn;
        @(posedge clk);
        model_edge(stb, w, rn);
        #1;
        chk("rxd",     32'(gmii_rxd), 32'(m_rxd));
        chk("locked",  32'(locked),   32'(m_locked));
        chk("slot",    32'(slot),     32'(m_slot));
        chk("realign", 32'(realign),  32'(m_realign));
        chk("stb_err", 32'(stb_err),  32'(m_err));
    endtask

    task automatic send(input logic [19:0] w);
        step(1'b1, w, 1'b1);
        step(1'b0, {rnd_data(), rnd_data()}, 1'b1);
    endtask

    initial begin
        logic pref;
        logic [19:0] w;
        int r;
        model_reset();

        // reset held with stb toggling
        for (int i = 0; i < 4; i++) step(1'(i % 2), {rnd_data(), rnd_data()}, 1'b0);
        chk("rst_rxd", 32'(gmii_rxd), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);

        // lock on low-half commas
        for (int i = 0; i < 3; i++) send({rnd_data(), KP});
        chk("t2_locked", 32'(locked), 32'd1);
        chk("t2_slot", 32'(slot), 32'd0);

        // three wrong-half commas keep lock, a good one clears, four drop it
        for (int i = 0; i < 3; i++) send({KN, rnd_data()});
        chk("t4_hold_lock", 32'(locked), 32'd1);
        send({rnd_data(), KP});
        for (int i = 0; i < 4; i++) send({KN, rnd_data()});
        chk("t4_unlock", 32'(locked), 32'd0);

        // lock on high-half commas
        for (int i = 0; i < 3; i++) send({KN, rnd_data()});
        chk("t3_slot", 32'(slot), 32'd1);
        chk("t3_locked", 32'(locked), 32'd1);

        // cadence faults
        step(1'b1, {rnd_data(), rnd_data()}, 1'b1);
        step(1'b1, {rnd_data(), rnd_data()}, 1'b1);
        chk("t5_err_adj", 32'(stb_err), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, {rnd_data(), rnd_data()}, 1'b1);
        chk("t5_err_gap", 32'(stb_err), 32'd1);
        chk("t5_locked", 32'(locked), 32'd1);

        // mid-stream reset, then relock on high half
        send({KN, rnd_data()});
        step(1'b0, {rnd_data(), rnd_data()}, 1'b0);
        chk("t6_slot", 32'(slot), 32'd0);
        chk("t6_rxd", 32'(gmii_rxd), 32'd0);
        for (int i = 0; i < 3; i++) send({KP, rnd_data()});
        chk("t6_relock", 32'(locked), 32'd1);

        // random traffic with a drifting preferred comma half
        pref = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom % 20 == 0) pref = ~pref;
            r = int'($urandom % 8);
            case (r)
                0, 1, 2, 3, 4: w = pref ? {rnd_k(), rnd_data()} : {rnd_data(), rnd_k()};
                5:             w = pref ? {rnd_data(), rnd_k()} : {rnd_k(), rnd_data()};
                6:             w = {rnd_k(), rnd_k()};
                default:       w = {rnd_data(), rnd_data()};
            endcase
            step(1'b1, w, ($urandom % 150 != 0));
            r = int'($urandom % 12);
            if (r == 0) begin
                // adjacent strobe next
            end else if (r == 1) begin
                for (int g = 0; g < 3; g++) step(1'b0, {rnd_data(), rnd_data()}, 1'b1);
            end else begin
                step(1'b0, {rnd_data(), rnd_data()}, 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
